// File: rtl/i17126_resp_checker_if.sv
// Handshake/result bundle between a response source (master) and the
// golden-response checker (slave).
interface i17126_resp_checker_if #(
  parameter int NW = 2
);
  logic          gold_load;
  logic [NW-1:0] gold_addr;
  logic          gold_data;
  logic          start;
  logic          rec_valid;
  logic          rec_ready;
  logic [NW-1:0] rec_vec;
  logic          rec_resp;
  logic          busy;
  logic          done;
  logic [NW:0]   mismatch_cnt;
  logic [NW-1:0] first_fail_vec;
  logic          first_fail_valid;
  logic          order_err;
  logic          gold_miss;
  logic          trojan_flag;

  modport master (
    output gold_load, gold_addr, gold_data, start, rec_valid, rec_vec, rec_resp,
    input  rec_ready, busy, done, mismatch_cnt, first_fail_vec, first_fail_valid,
           order_err, gold_miss, trojan_flag
  );

  modport slave (
    input  gold_load, gold_addr, gold_data, start, rec_valid, rec_vec, rec_resp,
    output rec_ready, busy, done, mismatch_cnt, first_fail_vec, first_fail_valid,
           order_err, gold_miss, trojan_flag
  );
endinterface

// File: rtl/i17126_resp_checker.sv
// Compares a sweep of DUT response records against a loadable golden table and
// flags mismatches, out-of-order records and unloaded golden entries.
module i17126_resp_checker #(
  parameter int NW = 2
) (
  input  logic                    CK,
  input  logic                    reset,
  i17126_resp_checker_if.slave    bus
);
  localparam int DEPTH = 1 << NW;
  localparam logic [NW-1:0] LAST_IDX = NW'(DEPTH - 1);
  localparam logic [NW:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] exp_q, exp_d;
  logic [NW:0]   cnt_q, cnt_d;
  logic [NW-1:0] ffvec_q, ffvec_d;
  logic          ffvalid_q, ffvalid_d;
  logic          order_q, order_d;
  logic          miss_q, miss_d;
  logic          in_check_q;
  logic          done_q;
  logic          trojan_q;

  logic          gold_mem [DEPTH];
  logic          loaded_q [DEPTH];

  logic          load_en;
  logic          hs;
  logic          gold_bit;
  logic          entry_loaded;
  logic          rec_bad;

  // Table writes are locked out for the whole sweep so the reference is stable.
  assign load_en      = reset && bus.gold_load && (state_q != CHECK);
  assign hs           = bus.rec_valid && in_check_q;
  assign gold_bit     = gold_mem[bus.rec_vec];
  assign entry_loaded = loaded_q[bus.rec_vec];
  assign rec_bad      = entry_loaded ? (bus.rec_resp != gold_bit) : 1'b1;

  always_ff @(posedge CK) begin
    if (load_en) begin
      gold_mem[bus.gold_addr] <= bus.gold_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_loaded
    always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
        loaded_q[gi] <= 1'b0;
      end else if (load_en && (bus.gold_addr == NW'(gi))) begin
        loaded_q[gi] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    ffvec_d   = ffvec_q;
    ffvalid_d = ffvalid_q;
    order_d   = order_q;
    miss_d    = miss_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = CHECK;
          exp_d     = '0;
          cnt_d     = '0;
          ffvec_d   = '0;
          ffvalid_d = 1'b0;
          order_d   = 1'b0;
          miss_d    = 1'b0;
        end
      end
      CHECK: begin
        if (hs) begin
          if (bus.rec_vec != exp_q) begin
            order_d = 1'b1;
          end
          exp_d = exp_q + 1'b1;
          if (rec_bad) begin
            if (!entry_loaded) begin
              miss_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (!ffvalid_q) begin
              ffvalid_d = 1'b1;
              ffvec_d   = bus.rec_vec;
            end
          end
          // The sweep length is fixed by handshake count, not by record order.
          if (exp_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      cnt_q      <= '0;
      ffvec_q    <= '0;
      ffvalid_q  <= 1'b0;
      order_q    <= 1'b0;
      miss_q     <= 1'b0;
      in_check_q <= 1'b0;
      done_q     <= 1'b0;
      trojan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      ffvec_q    <= ffvec_d;
      ffvalid_q  <= ffvalid_d;
      order_q    <= order_d;
      miss_q     <= miss_d;
      in_check_q <= (state_d == CHECK);
      done_q     <= (state_d == DONE);
      trojan_q   <= (state_d == DONE) && ((cnt_d != '0) || order_d || miss_d);
    end
  end

  assign bus.rec_ready        = in_check_q;
  assign bus.busy             = in_check_q;
  assign bus.done             = done_q;
  assign bus.mismatch_cnt     = cnt_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.first_fail_valid = ffvalid_q;
  assign bus.order_err        = order_q;
  assign bus.gold_miss        = miss_q;
  assign bus.trojan_flag      = trojan_q;

endmodule

// File: tb/tb_i17126_resp_checker.sv
// Table-driven, hand-sequenced and randomized checks of the response checker
// against a sweep-level reference model.
module tb_i17126_resp_checker;
  localparam int NW    = 2;
  localparam int DEPTH = 1 << NW;

  logic CK    = 1'b0;
  logic reset = 1'b0;

  i17126_resp_checker_if #(.NW(NW)) bus ();

  i17126_resp_checker #(.NW(NW)) dut (
    .CK    (CK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  bit m_gold   [DEPTH];
  bit m_loaded [DEPTH];

  typedef struct {
    logic [DEPTH-1:0]         gold;
    logic [DEPTH-1:0]         mask;
    logic [DEPTH-1:0][NW-1:0] vecs;
    logic [DEPTH-1:0]         resps;
    int cnt; int ffvec; int ffv; int ord; int miss; int troj;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_loaded[a] = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input int a, input bit d);
    bus.gold_load = 1'b1;
    bus.gold_addr = NW'(a);
    bus.gold_data = d;
    m_gold[a]     = d;
    m_loaded[a]   = 1'b1;
    tick();
    bus.gold_load = 1'b0;
  endtask

  task automatic start_sweep(input bit with_load, input int a, input bit d);
    bus.start = 1'b1;
    if (with_load) begin
      bus.gold_load = 1'b1;
      bus.gold_addr = NW'(a);
      bus.gold_data = d;
      m_gold[a]     = d;
      m_loaded[a]   = 1'b1;
    end
    tick();
    bus.start     = 1'b0;
    bus.gold_load = 1'b0;
  endtask

  // Offers one record after 'gap' idle cycles; noise injects ignored loads/starts.
  task automatic send(input logic [NW-1:0] v, input logic r, input int gap, input bit noise);
    int n;
    for (int g = 0; g < gap; g++) begin
      if (noise) begin
        bus.gold_load = 1'($urandom_range(0, 1));
        bus.gold_addr = NW'($urandom_range(0, DEPTH - 1));
        bus.gold_data = 1'($urandom_range(0, 1));
      end
      tick();
    end
    bus.rec_valid = 1'b1;
    bus.rec_vec   = v;
    bus.rec_resp  = r;
    if (noise) begin
      bus.gold_load = 1'($urandom_range(0, 1));
      bus.gold_addr = NW'($urandom_range(0, DEPTH - 1));
      bus.gold_data = 1'($urandom_range(0, 1));
      bus.start     = 1'($urandom_range(0, 1));
    end
    n = 0;
    while (bus.rec_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    if (n >= 16) chk("rec_ready_wait", int'(bus.rec_ready), 1);
    tick();
    bus.rec_valid = 1'b0;
    bus.gold_load = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic model_expect(input logic [DEPTH-1:0][NW-1:0] vecs, input logic [DEPTH-1:0] resps,
                              output int cnt, output int ffvec, output int ffv,
                              output int ord, output int miss, output int troj);
    cnt = 0; ffvec = 0; ffv = 0; ord = 0; miss = 0;
    for (int i = 0; i < DEPTH; i++) begin
      int v;
      bit bad;
      v   = int'(vecs[i]);
      bad = !m_loaded[v] || (resps[i] != m_gold[v]);
      if (v != i) ord = 1;
      if (!m_loaded[v]) miss = 1;
      if (bad) begin
        if (cnt == 0) begin
          ffvec = v;
          ffv   = 1;
        end
        cnt++;
      end
    end
    if (cnt > 2 * DEPTH - 1) cnt = 2 * DEPTH - 1;
    troj = (cnt > 0 || ord != 0 || miss != 0) ? 1 : 0;
  endtask

  task automatic check_results(input string tag, input int cnt, input int ffvec, input int ffv,
                               input int ord, input int miss, input int troj);
    chk({tag, ".done"},      int'(bus.done), 1);
    chk({tag, ".busy"},      int'(bus.busy), 0);
    chk({tag, ".rec_ready"}, int'(bus.rec_ready), 0);
    chk({tag, ".cnt"},       int'(bus.mismatch_cnt), cnt);
    chk({tag, ".ffvec"},     int'(bus.first_fail_vec), ffvec);
    chk({tag, ".ffvalid"},   int'(bus.first_fail_valid), ffv);
    chk({tag, ".order"},     int'(bus.order_err), ord);
    chk({tag, ".miss"},      int'(bus.gold_miss), miss);
    chk({tag, ".trojan"},    int'(bus.trojan_flag), troj);
    $display("sweep %s: cnt=%0d ffvec=%0d ffv=%0d ord=%0d miss=%0d troj=%0d", tag,
             bus.mismatch_cnt, bus.first_fail_vec, bus.first_fail_valid,
             bus.order_err, bus.gold_miss, bus.trojan_flag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},      int'(bus.busy), 0);
    chk({tag, ".rec_ready"}, int'(bus.rec_ready), 0);
    chk({tag, ".done"},      int'(bus.done), 0);
    chk({tag, ".cnt"},       int'(bus.mismatch_cnt), 0);
    chk({tag, ".ffvec"},     int'(bus.first_fail_vec), 0);
    chk({tag, ".ffvalid"},   int'(bus.first_fail_valid), 0);
    chk({tag, ".order"},     int'(bus.order_err), 0);
    chk({tag, ".miss"},      int'(bus.gold_miss), 0);
    chk({tag, ".trojan"},    int'(bus.trojan_flag), 0);
  endtask

  task automatic full_gold();
    load(0, 1'b0); load(1, 1'b1); load(2, 1'b1); load(3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DEPTH-1:0][NW-1:0] vecs;
    logic [DEPTH-1:0]         resps;
    int e_cnt, e_ffvec, e_ffv, e_ord, e_miss, e_troj;

    bus.gold_load = 1'b0; bus.gold_addr = '0; bus.gold_data = 1'b0;
    bus.start = 1'b0; bus.rec_valid = 1'b0; bus.rec_vec = '0; bus.rec_resp = 1'b0;

    tbl[0] = '{gold:4'b0110, mask:4'b1111, vecs:8'b11_10_01_00, resps:4'b0110,
               cnt:0, ffvec:0, ffv:0, ord:0, miss:0, troj:0};
    tbl[1] = '{gold:4'b0110, mask:4'b1111, vecs:8'b11_10_01_00, resps:4'b1100,
               cnt:2, ffvec:1, ffv:1, ord:0, miss:0, troj:1};
    tbl[2] = '{gold:4'b0110, mask:4'b1111, vecs:8'b11_01_10_00, resps:4'b0110,
               cnt:0, ffvec:0, ffv:0, ord:1, miss:0, troj:1};
    tbl[3] = '{gold:4'b0110, mask:4'b0111, vecs:8'b11_10_01_00, resps:4'b0110,
               cnt:1, ffvec:3, ffv:1, ord:0, miss:1, troj:1};
    tbl[4] = '{gold:4'b0110, mask:4'b1111, vecs:8'b11_10_01_00, resps:4'b1001,
               cnt:4, ffvec:0, ffv:1, ord:0, miss:0, troj:1};

    apply_reset();
    check_all_zero("reset");

    for (int t = 0; t < 5; t++) begin
      apply_reset();
      for (int a = 0; a < DEPTH; a++) if (tbl[t].mask[a]) load(a, tbl[t].gold[a]);
      start_sweep(1'b0, 0, 1'b0);
      chk($sformatf("tbl%0d.busy", t), int'(bus.busy), 1);
      chk($sformatf("tbl%0d.trojan_in_check", t), int'(bus.trojan_flag), 0);
      for (int i = 0; i < DEPTH; i++) send(tbl[t].vecs[i], tbl[t].resps[i], 0, 1'b0);
      check_results($sformatf("tbl%0d", t), tbl[t].cnt, tbl[t].ffvec, tbl[t].ffv,
                    tbl[t].ord, tbl[t].miss, tbl[t].troj);
    end

    // Gaps and blocked loads during the sweep; a follow-up sweep proves the table held.
    apply_reset();
    full_gold();
    start_sweep(1'b0, 0, 1'b0);
    send(2'd0, 1'b0, 2, 1'b0);
    bus.gold_load = 1'b1; bus.gold_addr = 2'd1; bus.gold_data = 1'b0;
    send(2'd1, 1'b1, 0, 1'b0);
    bus.gold_load = 1'b1; bus.gold_addr = 2'd2; bus.gold_data = 1'b0;
    send(2'd2, 1'b1, 3, 1'b0);
    chk("gaps.done_after3", int'(bus.done), 0);
    bus.gold_load = 1'b1; bus.gold_addr = 2'd0; bus.gold_data = 1'b1;
    send(2'd3, 1'b1, 1, 1'b0);
    check_results("gaps", 1, 3, 1, 0, 0, 1);
    start_sweep(1'b0, 0, 1'b0);
    chk("restart.cnt_cleared", int'(bus.mismatch_cnt), 0);
    chk("restart.ffvalid_cleared", int'(bus.first_fail_valid), 0);
    chk("restart.busy", int'(bus.busy), 1);
    chk("restart.trojan", int'(bus.trojan_flag), 0);
    for (int i = 0; i < DEPTH; i++) send(NW'(i), m_gold[i], 1, 1'b0);
    check_results("table_kept", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a sweep with non-zero results pending.
    apply_reset();
    full_gold();
    start_sweep(1'b0, 0, 1'b0);
    send(2'd1, 1'b0, 0, 1'b0);
    send(2'd1, 1'b1, 0, 1'b0);
    chk("pre_reset.cnt", int'(bus.mismatch_cnt), 1);
    #2;
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_loaded[a] = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge CK);
    #1;
    reset = 1'b1;
    start_sweep(1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(NW'(i), m_gold[i], 0, 1'b0);
    check_results("loaded_cleared", 4, 0, 1, 0, 1, 1);
    full_gold();
    start_sweep(1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(NW'(i), m_gold[i], 0, 1'b0);
    check_results("after_reset", 0, 0, 0, 0, 0, 0);

    // Load of the last entry in the same cycle as start must be used by the sweep.
    apply_reset();
    load(0, 1'b0); load(1, 1'b1); load(2, 1'b1);
    start_sweep(1'b1, 3, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(NW'(i), m_gold[i], 0, 1'b0);
    check_results("load_with_start", 0, 0, 0, 0, 0, 0);

    for (int s = 0; s < 40; s++) begin
      int nl;
      if ($urandom_range(0, 1) == 1) apply_reset();
      nl = $urandom_range(0, 6);
      for (int k = 0; k < nl; k++) load($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
      start_sweep(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
      for (int i = 0; i < DEPTH; i++) begin
        int v;
        v = ($urandom_range(0, 9) < 7) ? i : $urandom_range(0, DEPTH - 1);
        vecs[i]  = NW'(v);
        resps[i] = (m_loaded[v] && $urandom_range(0, 9) < 8) ? m_gold[v] : 1'($urandom_range(0, 1));
      end
      model_expect(vecs, resps, e_cnt, e_ffvec, e_ffv, e_ord, e_miss, e_troj);
      for (int i = 0; i < DEPTH; i++) begin
        send(vecs[i], resps[i], $urandom_range(0, 2), 1'b1);
        if (i == DEPTH - 2) chk($sformatf("rnd%0d.done_early", s), int'(bus.done), 0);
      end
      check_results($sformatf("rnd%0d", s), e_cnt, e_ffvec, e_ffv, e_ord, e_miss, e_troj);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i17126_resp_checker.md
I17126_RESP_CHECKER -- requirements
Module: i17126_resp_checker

Interface
REQ-001 SHALL have parameter NW, default 2, meaning DUT input-vector width; DEPTH = 2**NW records per sweep.
REQ-002 SHALL have port CK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL have port gold_load  input  1  write strobe for the golden response table.
REQ-005 SHALL have port gold_addr  input  NW  golden table index (input vector).
REQ-006 SHALL have port gold_data  input  1  expected single-bit response for gold_addr.
REQ-007 SHALL have port start  input  1  begin a check sweep.
REQ-008 SHALL have port rec_valid  input  1  response record offered.
REQ-009 SHALL have port rec_ready  output  1  record accepted when rec_valid && rec_ready.
REQ-010 SHALL have port rec_vec  input  NW  vector applied to the DUT for this record.
REQ-011 SHALL have port rec_resp  input  1  DUT output_single sampled for rec_vec.
REQ-012 SHALL have port busy  output  1  high in CHECK.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port mismatch_cnt  output  NW+1  count of response mismatches this sweep.
REQ-015 SHALL have port first_fail_vec  output  NW  rec_vec of first mismatching record.
REQ-016 SHALL have port first_fail_valid  output  1  first_fail_vec holds a captured value.
REQ-017 SHALL have port order_err  output  1  sticky: record arrived out of ascending order.
REQ-018 SHALL have port gold_miss  output  1  sticky: record checked against an unloaded golden entry.
REQ-019 SHALL have port trojan_flag  output  1  high in DONE when any mismatch, order_err or gold_miss.

Function
REQ-020 SHALL implement states IDLE, CHECK, DONE; reset enters IDLE.
REQ-021 SHALL write gold[gold_addr]=gold_data and set loaded[gold_addr] on gold_load only in IDLE or DONE; gold_load in CHECK ignored.
REQ-022 SHALL on start in IDLE or DONE enter CHECK next cycle, clearing mismatch_cnt, first_fail_valid, first_fail_vec, order_err, gold_miss, expected index exp=0; golden table retained.
REQ-023 SHALL drive rec_ready=1 exactly in CHECK, 0 elsewhere; start ignored in CHECK.
REQ-024 SHALL on each handshake set order_err if rec_vec != exp, then increment exp modulo DEPTH.
REQ-025 SHALL count a mismatch when loaded[rec_vec]=0 (also set gold_miss) or rec_resp != gold[rec_vec].
REQ-026 SHALL increment mismatch_cnt by one per mismatching record, saturating at all-ones.
REQ-027 SHALL capture first_fail_vec=rec_vec and set first_fail_valid only on the first mismatch of a sweep.
REQ-028 SHALL register all outputs; effects of a handshake visible the cycle after it.
REQ-029 SHALL transition CHECK->DONE on the handshake where exp == DEPTH-1 (exp wraps to 0), regardless of order_err.
REQ-030 SHALL hold all results stable in DONE until next start; trojan_flag = 0 outside DONE.
REQ-031 SHALL, on gold_load and handshake in the same cycle, never occur (load blocked in CHECK); start with gold_load in same IDLE cycle: load applied, sweep uses new entry.

Reset
REQ-032 SHALL on reset low asynchronously force IDLE, rec_ready=0, busy=0, done=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, order_err=0, gold_miss=0, trojan_flag=0, exp=0, all loaded bits 0.
REQ-033 SHALL abandon a sweep in progress on reset; release synchronous to CK, first start honored on the first rising edge after release.

Verification
REQ-034 Load gold {00:0,01:1,10:1,11:0}; start; records 00/0,01/1,10/1,11/0 -> done=1, mismatch_cnt=0, trojan_flag=0, order_err=0.
REQ-035 Same gold; records 00/0,01/0,10/1,11/1 -> mismatch_cnt=2, first_fail_vec=01, trojan_flag=1.
REQ-036 Same gold; records 00,10,01,11 with correct responses -> order_err=1, mismatch_cnt=0, trojan_flag=1, done after 4th record.
REQ-037 Load only 00,01,10; full correct sweep -> gold_miss=1, mismatch_cnt=1, first_fail_vec=11.
REQ-038 rec_valid toggled with gaps and gold_load pulsed during CHECK -> only handshaked records counted, table unchanged, done after exactly 4 handshakes.
REQ-039 Assert reset low after 2 records -> all outputs reset immediately; loaded bits cleared; new load+sweep behaves as REQ-034.
